skin_centroid_tracker: RTL and testbench

- Downstream consumer of the 3x3 mean-filtered skin-mask stream (Y carries the smoothed mask; Cb/Cr are pass-through).
- Thresholds each active pixel and accumulates its x/y coordinates and the hit count per frame.
- At frame end, a serial divide produces the skin-region centroid.
- Optionally overlays a crosshair at the previous frame's centroid on the outgoing video.

---
 rtl/skin_centroid_tracker_pkg.sv | 20 ++
 rtl/skin_centroid_tracker_if.sv | 36 +++
 rtl/skin_centroid_tracker_serial_divider.sv | 75 +++++++
 rtl/skin_centroid_tracker.sv | 128 ++++++++++++
 tb/tb_skin_centroid_tracker.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/skin_centroid_tracker_pkg.sv
// Shared widths, FSM encoding and helpers for the skin-region centroid tracker.
package skin_centroid_tracker_pkg;

  localparam int COORD_W = 10;
  localparam int CNT_W   = 21;
  localparam int SUM_W   = 31;

  localparam logic [7:0] OVERLAY_Y = 8'hFF;

  typedef enum logic [1:0] {
    ACC  = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic is_skin(input logic [7:0] y, input logic [7:0] thresh);
    return y >= thresh;
  endfunction

endpackage

// File: rtl/skin_centroid_tracker_if.sv
// Video stream in/out plus per-frame centroid results of the tracker.
interface skin_centroid_tracker_if;
  import skin_centroid_tracker_pkg::*;

  logic [7:0]         in_Y;
  logic [7:0]         in_Cb;
  logic [7:0]         in_Cr;
  logic               in_de;
  logic               in_vsync;
  logic               in_hsync;
  logic [7:0]         out_Y;
  logic [7:0]         out_Cb;
  logic [7:0]         out_Cr;
  logic               out_de;
  logic               out_vsync;
  logic               out_hsync;
  logic [COORD_W-1:0] out_cx;
  logic [COORD_W-1:0] out_cy;
  logic [CNT_W-1:0]   out_count;
  logic               out_found;
  logic               out_valid;
  logic               out_overrun;

  modport master (
    output in_Y, in_Cb, in_Cr, in_de, in_vsync, in_hsync,
    input  out_Y, out_Cb, out_Cr, out_de, out_vsync, out_hsync,
    input  out_cx, out_cy, out_count, out_found, out_valid, out_overrun
  );

  modport slave (
    input  in_Y, in_Cb, in_Cr, in_de, in_vsync, in_hsync,
    output out_Y, out_Cb, out_Cr, out_de, out_vsync, out_hsync,
    output out_cx, out_cy, out_count, out_found, out_valid, out_overrun
  );

endinterface

// File: rtl/skin_centroid_tracker_serial_divider.sv
// Restoring unsigned divider, one quotient bit per ce-cycle, DVD_W iterations.
module serial_divider #(
  parameter int DVD_W = 31,
  parameter int DVS_W = 21,
  parameter int Q_W   = 10
) (
  input  logic             clk,
  input  logic             ce,
  input  logic             rst,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic [Q_W-1:0]   quotient,
  output logic             busy,
  output logic             done
);

  localparam int STEP_W = $clog2(DVD_W + 1);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(DVD_W - 1);

  logic             busy_q, busy_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [DVS_W-1:0] rem_q, rem_d;
  logic [DVS_W-1:0] dvs_q, dvs_d;
  logic [DVD_W-1:0] quo_q, quo_d;
  logic [DVS_W:0]   rem_sh;
  logic [DVS_W:0]   trial;

  // Dividend shifts out of quo_q MSB-first while quotient bits shift in at the LSB.
  always_comb begin
    busy_d = busy_q;
    step_d = step_q;
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    quo_d  = quo_q;
    rem_sh = {rem_q, quo_q[DVD_W-1]};
    trial  = rem_sh - {1'b0, dvs_q};
    if (start) begin
      busy_d = 1'b1;
      step_d = '0;
      rem_d  = '0;
      dvs_d  = divisor;
      quo_d  = dividend;
    end else if (busy_q) begin
      if (!trial[DVS_W]) begin
        rem_d = trial[DVS_W-1:0];
        quo_d = {quo_q[DVD_W-2:0], 1'b1};
      end else begin
        rem_d = rem_sh[DVS_W-1:0];
        quo_d = {quo_q[DVD_W-2:0], 1'b0};
      end
      step_d = step_q + STEP_W'(1);
      if (step_q == LAST_STEP) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= 1'b0;
    else if (ce) busy_q <= busy_d;
  end

  always_ff @(posedge clk) begin
    if (ce) begin
      step_q <= step_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      quo_q  <= quo_d;
    end
  end

  assign quotient = quo_q[Q_W-1:0];
  assign busy     = busy_q;
  assign done     = busy_q && (step_q == LAST_STEP);

endmodule

// File: rtl/skin_centroid_tracker.sv
// Thresholds a smoothed skin mask, accumulates hit coordinates per frame and
// divides at frame end to report the centroid; optionally draws a crosshair.
module skin_centroid_tracker
  import skin_centroid_tracker_pkg::*;
#(
  parameter logic [7:0] THRESH  = 8'd128,
  parameter bit         OVERLAY = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic ce,
  skin_centroid_tracker_if.slave bus
);

  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic               de_q, vsync_q, hs_q, fe_q, fe_d;
  logic [7:0]         out_y_q, out_y_d, cb_q, cr_q;
  logic [SUM_W-1:0]   sum_x_q, sum_x_d, sum_y_q, sum_y_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               frame_end, hit, div_start;

  state_e             state_q;
  logic [COORD_W-1:0] cx_q, cy_q;
  logic [CNT_W-1:0]   count_q, snap_cnt_q;
  logic               found_q, valid_q, overrun_q, xhair_q;

  logic [COORD_W-1:0] qx, qy;
  logic               busy_x, busy_y, done_x, done_y;

  always_comb begin
    frame_end = bus.in_vsync & ~vsync_q;
    fe_d      = frame_end;
    hit       = bus.in_de & is_skin(bus.in_Y, THRESH);
    x_d       = bus.in_de ? x_q + COORD_W'(1) : '0;
    y_d       = y_q;
    if (frame_end)               y_d = '0;
    else if (de_q & ~bus.in_de)  y_d = y_q + COORD_W'(1);
    sum_x_d = sum_x_q;
    sum_y_d = sum_y_q;
    cnt_d   = cnt_q;
    // The registered frame-end pulse clears the sums the same edge the FSM snapshots them.
    if (fe_q) begin
      sum_x_d = '0;
      sum_y_d = '0;
      cnt_d   = '0;
    end else if (hit) begin
      sum_x_d = sum_x_q + SUM_W'(x_q);
      sum_y_d = sum_y_q + SUM_W'(y_q);
      cnt_d   = cnt_q + CNT_W'(1);
    end
    out_y_d = bus.in_Y;
    if (OVERLAY && xhair_q && bus.in_de && (x_q == cx_q || y_q == cy_q)) out_y_d = OVERLAY_Y;
    div_start = (state_q == ACC) && fe_q && (cnt_q != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q <= '0; y_q <= '0; de_q <= 1'b0; vsync_q <= 1'b0; hs_q <= 1'b0; fe_q <= 1'b0;
      out_y_q <= '0; cb_q <= '0; cr_q <= '0;
      sum_x_q <= '0; sum_y_q <= '0; cnt_q <= '0;
    end else if (ce) begin
      x_q <= x_d; y_q <= y_d; de_q <= bus.in_de; vsync_q <= bus.in_vsync;
      hs_q <= bus.in_hsync; fe_q <= fe_d;
      out_y_q <= out_y_d; cb_q <= bus.in_Cb; cr_q <= bus.in_Cr;
      sum_x_q <= sum_x_d; sum_y_q <= sum_y_d; cnt_q <= cnt_d;
    end
  end

  serial_divider #(.DVD_W(SUM_W), .DVS_W(CNT_W), .Q_W(COORD_W)) u_div_x (
    .clk(clk), .ce(ce), .rst(rst), .start(div_start), .dividend(sum_x_q),
    .divisor(cnt_q), .quotient(qx), .busy(busy_x), .done(done_x)
  );

  serial_divider #(.DVD_W(SUM_W), .DVS_W(CNT_W), .Q_W(COORD_W)) u_div_y (
    .clk(clk), .ce(ce), .rst(rst), .start(div_start), .dividend(sum_y_q),
    .divisor(cnt_q), .quotient(qy), .busy(busy_y), .done(done_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACC; cx_q <= '0; cy_q <= '0; count_q <= '0; snap_cnt_q <= '0;
      found_q <= 1'b0; valid_q <= 1'b0; overrun_q <= 1'b0; xhair_q <= 1'b0;
    end else if (ce) begin
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      case (state_q)
        ACC: begin
          if (fe_q) begin
            snap_cnt_q <= cnt_q;
            state_q    <= (cnt_q != '0) ? DIV : DONE;
          end
        end
        DIV: begin
          if (fe_q) overrun_q <= 1'b1;
          // The busy fallback only guards against a divider that never ran.
          if ((done_x && done_y) || !(busy_x || busy_y)) state_q <= DONE;
        end
        DONE: begin
          if (fe_q) overrun_q <= 1'b1;
          valid_q <= 1'b1;
          count_q <= snap_cnt_q;
          found_q <= (snap_cnt_q != '0);
          xhair_q <= (snap_cnt_q != '0);
          if (snap_cnt_q != '0) begin
            cx_q <= qx;
            cy_q <= qy;
          end
          state_q <= ACC;
        end
        default: state_q <= ACC;
      endcase
    end
  end

  assign bus.out_Y       = out_y_q;
  assign bus.out_Cb      = cb_q;
  assign bus.out_Cr      = cr_q;
  assign bus.out_de      = de_q;
  assign bus.out_vsync   = vsync_q;
  assign bus.out_hsync   = hs_q;
  assign bus.out_cx      = cx_q;
  assign bus.out_cy      = cy_q;
  assign bus.out_count   = count_q;
  assign bus.out_found   = found_q;
  assign bus.out_valid   = valid_q;
  assign bus.out_overrun = overrun_q;

endmodule

// File: tb/tb_skin_centroid_tracker.sv
// Directed frames with hand-computed centroids, latencies and crosshair pixels.
module tb_skin_centroid_tracker;

  localparam int W      = 16;
  localparam int H      = 8;
  localparam int HBLANK = 4;

  logic clk = 1'b0;
  logic rst;
  logic ce;
  always #5 clk = ~clk;

  skin_centroid_tracker_if bus ();

  skin_centroid_tracker #(.THRESH(8'd128), .OVERLAY(1'b1)) dut (
    .clk(clk), .rst(rst), .ce(ce), .bus(bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  bit exp_xhair = 1'b0;
  int exp_cx    = 0;
  int exp_cy    = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pix(input int mode, input int x, input int y);
    case (mode)
      1:       return (x >= 4 && x <= 7 && y >= 2 && y <= 5) ? 8'd255 : 8'd0;
      2:       return (x == 3 && y == 3) ? 8'd127 : ((x == 9 && y == 1) ? 8'd128 : 8'd0);
      default: return 8'd0;
    endcase
  endfunction

  task automatic send_frame(input int mode, output int nvalid);
    logic [7:0]  ey;
    logic [26:0] ctl_got, ctl_exp;
    nvalid = 0;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        bus.in_Y = pix(mode, x, y); bus.in_Cb = 8'(x * 3); bus.in_Cr = 8'(y + 100);
        bus.in_de = 1'b1; bus.in_hsync = 1'b0; bus.in_vsync = 1'b0;
        step();
        ey = (exp_xhair && (x == exp_cx || y == exp_cy)) ? 8'd255 : pix(mode, x, y);
        chk("video_y", 32'(bus.out_Y), 32'(ey));
        ctl_got = {bus.out_de, bus.out_hsync, bus.out_vsync, bus.out_Cb, bus.out_Cr};
        ctl_exp = {1'b1, 1'b0, 1'b0, 8'(x * 3), 8'(y + 100)};
        chk("video_ctl", 32'(ctl_got), 32'(ctl_exp));
        if (bus.out_valid) nvalid++;
      end
      for (int b = 0; b < HBLANK; b++) begin
        bus.in_Y = 8'd0; bus.in_de = 1'b0; bus.in_hsync = 1'b1;
        step();
        if (bus.out_valid) nvalid++;
      end
    end
  endtask

  // n counts edges from the first one sampling in_vsync=1 (edge t is n=0).
  task automatic frame_end(input int second_vs, input int rst_at, input int ce_gap_at,
                           output int lat, output int nvalid, output int novr);
    bus.in_vsync = 1'b1; bus.in_de = 1'b0; bus.in_Y = 8'd0;
    lat = -1; nvalid = 0; novr = 0;
    for (int n = 0; n < 60; n++) begin
      step();
      if (n == 1) bus.in_vsync = 1'b0;
      if (second_vs >= 0 && n == second_vs) bus.in_vsync = 1'b1;
      if (second_vs >= 0 && n == second_vs + 2) bus.in_vsync = 1'b0;
      if (rst_at >= 0 && n == rst_at) rst = 1'b1;
      if (rst_at >= 0 && n == rst_at + 2) rst = 1'b0;
      if (ce_gap_at >= 0 && n == ce_gap_at) ce = 1'b0;
      if (ce_gap_at >= 0 && n == ce_gap_at + 5) ce = 1'b1;
      if (bus.out_valid) begin
        if (lat < 0) lat = n;
        nvalid++;
      end
      if (bus.out_overrun) novr++;
    end
  endtask

  task automatic chk_result(input string tag, input int cnt, input int cx, input int cy, input int found);
    chk({tag, "_count"}, 32'(bus.out_count), 32'(cnt));
    chk({tag, "_cx"},    32'(bus.out_cx),    32'(cx));
    chk({tag, "_cy"},    32'(bus.out_cy),    32'(cy));
    chk({tag, "_found"}, 32'(bus.out_found), 32'(found));
  endtask

  initial begin
    int lat, nv, novr;

    // Reset asserted mid-stream with bright pixels on the input.
    rst = 1'b1; ce = 1'b1;
    bus.in_Y = 8'd255; bus.in_Cb = 8'd77; bus.in_Cr = 8'd88;
    bus.in_de = 1'b1; bus.in_vsync = 1'b0; bus.in_hsync = 1'b0;
    repeat (3) step();
    chk("rst_video", 32'({bus.out_Y, bus.out_Cb, bus.out_Cr}), 32'd0);
    chk("rst_ctl", 32'({bus.out_de, bus.out_vsync, bus.out_hsync}), 32'd0);
    chk("rst_flags", 32'({bus.out_found, bus.out_valid, bus.out_overrun}), 32'd0);
    chk_result("rst", 0, 0, 0, 0);
    rst = 1'b0; bus.in_de = 1'b0; bus.in_Y = 8'd0; bus.in_hsync = 1'b1;
    repeat (4) step();

    // 4x4 block at x=4..7, y=2..5: centroid floor(5.5)=5, floor(3.5)=3.
    send_frame(1, nv);
    chk("no_early_valid", 32'(nv), 32'd0);
    frame_end(-1, -1, -1, lat, nv, novr);
    chk("f1_latency", 32'(lat), 32'd33);
    chk("f1_pulses", 32'(nv), 32'd1);
    chk("f1_overrun", 32'(novr), 32'd0);
    chk_result("f1", 16, 5, 3, 1);
    exp_xhair = 1'b1; exp_cx = 5; exp_cy = 3;

    // Empty frame shows the crosshair, then reports found=0 and keeps the centroid.
    send_frame(0, nv);
    frame_end(-1, -1, -1, lat, nv, novr);
    chk("f2_latency", 32'(lat), 32'd2);
    chk("f2_pulses", 32'(nv), 32'd1);
    chk_result("f2", 0, 5, 3, 0);
    exp_xhair = 1'b0;

    // Threshold edge: 127 rejected, 128 accepted; crosshair now disabled.
    send_frame(2, nv);
    frame_end(-1, -1, -1, lat, nv, novr);
    chk("f3_latency", 32'(lat), 32'd33);
    chk_result("f3", 1, 9, 1, 1);
    exp_xhair = 1'b1; exp_cx = 9; exp_cy = 1;

    // Second vsync rise 10 cycles into the divide.
    send_frame(1, nv);
    frame_end(10, -1, -1, lat, nv, novr);
    chk("f4_latency", 32'(lat), 32'd33);
    chk("f4_pulses", 32'(nv), 32'd1);
    chk("f4_overrun", 32'(novr), 32'd1);
    chk_result("f4", 16, 5, 3, 1);
    exp_cx = 5; exp_cy = 3;

    // Reset in the middle of the divide aborts the result.
    send_frame(2, nv);
    frame_end(-1, 15, -1, lat, nv, novr);
    chk("f5_pulses", 32'(nv), 32'd0);
    chk("f5_flags", 32'({bus.out_valid, bus.out_overrun}), 32'd0);
    chk_result("f5", 0, 0, 0, 0);
    exp_xhair = 1'b0; exp_cx = 0; exp_cy = 0;

    // Fresh frame after the abort; a 5-cycle ce gap stretches the latency.
    send_frame(1, nv);
    frame_end(-1, -1, 5, lat, nv, novr);
    chk("f6_latency", 32'(lat), 32'd38);
    chk("f6_pulses", 32'(nv), 32'd1);
    chk_result("f6", 16, 5, 3, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
